sysinfo_slave: RTL and testbench

Parametrised system-information Avalon-MM slave, the next generation of the fixed two-word system ID peripheral. It returns build constants (system ID, build timestamp) and adds a 64-bit uptime counter with atomic snapshot, a scratch register and a control/status register. Read data comes back through a configurable fixed-latency pipeline with `readdatavalid`. It sits on the CPU data master's peripheral bus beside the other control slaves.

---
 rtl/sysinfo_slave.sv | 135 +++++++++++++
 tb/tb_sysinfo_slave.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sysinfo_slave.sv
// rtl/sysinfo_slave.sv - system information slave: build constants, 64-bit uptime with snapshot, scratch, control/status
module sysinfo_slave #(
    parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'd1351705187,
    parameter int          ADDR_W       = 3,
    parameter int          READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam logic [7:0] A_ID      = 8'd0;
    localparam logic [7:0] A_TS      = 8'd1;
    localparam logic [7:0] A_UP_LO   = 8'd2;
    localparam logic [7:0] A_UP_HI   = 8'd3;
    localparam logic [7:0] A_SCRATCH = 8'd4;
    localparam logic [7:0] A_CTRL    = 8'd5;

    logic [7:0]  addr_w;
    logic        rd_acc;
    logic        wr_acc;
    logic        ctrl_wr;
    logic        scr_wr;
    logic        clr;
    logic        wrap;

    logic [63:0] cnt_q,      cnt_d;
    logic [31:0] hi_snap_q,  hi_snap_d;
    logic [31:0] scratch_q,  scratch_d;
    logic        en_q,       en_d;
    logic        ovf_q,      ovf_d;
    logic [31:0] rd_mux;

    logic [31:0]             pipe_data_q [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_vld_q;

    // A read in the same cycle as a write wins; the write is dropped.
    assign addr_w  = 8'(address);
    assign rd_acc  = read;
    assign wr_acc  = write & ~read;
    assign ctrl_wr = wr_acc && (addr_w == A_CTRL);
    assign scr_wr  = wr_acc && (addr_w == A_SCRATCH);
    assign clr     = ctrl_wr && writedata[1];
    assign wrap    = en_q && (cnt_q == '1) && !clr;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en_q) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_comb begin
        en_d  = ctrl_wr ? writedata[0] : en_q;
        // A wrap in the same cycle as a write-1-to-clear leaves OVF set.
        ovf_d = wrap | (ovf_q & ~(ctrl_wr & writedata[8]));
    end

    always_comb begin
        hi_snap_d = hi_snap_q;
        if (rd_acc && (addr_w == A_UP_LO)) begin
            hi_snap_d = cnt_q[63:32];
        end
    end

    always_comb begin
        scratch_d = scratch_q;
        if (scr_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    scratch_d[b*8 +: 8] = writedata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr_w)
            A_ID:      rd_mux = SYSTEM_ID;
            A_TS:      rd_mux = TIMESTAMP;
            A_UP_LO:   rd_mux = cnt_q[31:0];
            A_UP_HI:   rd_mux = hi_snap_q;
            A_SCRATCH: rd_mux = scratch_q;
            A_CTRL:    rd_mux = {23'b0, ovf_q, 7'b0, en_q};
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            hi_snap_q <= '0;
            scratch_q <= '0;
            en_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_snap_q <= hi_snap_d;
            scratch_q <= scratch_d;
            en_q      <= en_d;
            ovf_q     <= ovf_d;
        end
    end

    // Data is zeroed on entry when no read is accepted, so readdata is 0 whenever invalid.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= rd_acc;
            pipe_data_q[0] <= rd_acc ? rd_mux : 32'd0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_data_q[i] <= pipe_data_q[i-1];
            end
        end
    end

    assign readdata      = pipe_data_q[READ_LATENCY-1];
    assign readdatavalid = pipe_vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_sysinfo_slave.sv
// tb/tb_sysinfo_slave.sv - scoreboard bench for sysinfo_slave
module tb_sysinfo_slave;

    localparam int          ADDR_W = 4;
    localparam int          RL     = 3;
    localparam logic [31:0] SYS_ID = 32'h0000_0000;
    localparam logic [31:0] TS     = 32'd1351705187;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic              read = 1'b0;
    logic              write = 1'b0;
    logic [31:0]       writedata = '0;
    logic [3:0]        byteenable = '0;
    logic [31:0]       readdata;
    logic              readdatavalid;

    typedef struct {
        logic [31:0] data;
        int          due;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_x;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] cnt_ref;
    int          ref_cyc;
    int          c;
    logic [31:0] frozen;

    sysinfo_slave #(
        .SYSTEM_ID(SYS_ID),
        .TIMESTAMP(TS),
        .ADDR_W(ADDR_W),
        .READ_LATENCY(RL)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .address(address),
        .read(read),
        .write(write),
        .writedata(writedata),
        .byteenable(byteenable),
        .readdata(readdata),
        .readdatavalid(readdatavalid)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Counter value sampled by a read driven while cyc == cc (accepted at edge cc+1).
    function automatic logic [63:0] cnt_at(input int cc);
        return cnt_ref + 64'(cc - ref_cyc);
    endfunction

    function automatic logic [31:0] lo_at(input int cc);
        logic [63:0] v;
        v = cnt_at(cc);
        return v[31:0];
    endfunction

    function automatic logic [31:0] hi_at(input int cc);
        logic [63:0] v;
        v = cnt_at(cc);
        return v[63:32];
    endfunction

    task automatic push_exp(input logic [31:0] want, input string nm);
        exp_t x;
        x.data = want;
        x.due  = cyc + RL;
        x.name = nm;
        sb.push_back(x);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] want, input string nm);
        push_exp(want, nm);
        read    = 1'b1;
        write   = 1'b0;
        address = a;
        @(negedge clock);
        read = 1'b0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
        write      = 1'b1;
        read       = 1'b0;
        address    = a;
        writedata  = d;
        byteenable = be;
        @(negedge clock);
        write = 1'b0;
    endtask

    // Monitor: samples just after each rising edge, pops the scoreboard on every valid.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (readdatavalid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got readdata %h with no read outstanding (cycle %0d)", readdata, cyc);
                end else begin
                    mon_x = sb.pop_front();
                    chk(mon_x.name, readdata, mon_x.data);
                    chk({mon_x.name, "_latency"}, 32'(cyc), 32'(mon_x.due));
                end
            end else begin
                chk("idle_data_zero", readdata, 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

    initial begin
        repeat (4) @(negedge clock);
        chk("rst_valid", {31'b0, readdatavalid}, 32'd0);
        chk("rst_data", readdata, 32'd0);
        reset_n = 1'b1;
        cnt_ref = '0;
        ref_cyc = cyc;

        rd(0,  SYS_ID, "id");
        rd(1,  TS,     "ts");
        rd(6,  32'd0,  "w6");
        rd(9,  32'd0,  "w9");
        rd(15, 32'd0,  "w15");

        c = cyc;
        rd(2, lo_at(c), "up_lo");
        rd(3, hi_at(c), "up_hi");

        wr(4, 32'hDEAD_BEEF, 4'hF);
        wr(4, 32'h0000_0055, 4'b0001);
        rd(4, 32'hDEAD_BE55, "scr_be");
        push_exp(32'hDEAD_BE55, "scr_rw_old");
        read = 1'b1; write = 1'b1; address = 4; writedata = 32'h1234_5678; byteenable = 4'hF;
        @(negedge clock);
        read = 1'b0; write = 1'b0;
        rd(4, 32'hDEAD_BE55, "scr_drop");

        c = cyc;
        wr(5, 32'h0, 4'hF);
        frozen = lo_at(c + 1);
        repeat (100) @(negedge clock);
        rd(2, frozen, "frozen");
        rd(5, 32'h0, "ctrl_en0");
        wr(5, 32'h2, 4'hF);
        rd(2, 32'h0, "clr_lo");
        rd(5, 32'h0, "ctrl_clr");
        c = cyc;
        wr(5, 32'h1, 4'hF);
        cnt_ref = '0; ref_cyc = c + 1;
        repeat (7) @(negedge clock);
        rd(2, lo_at(cyc), "resume");
        rd(5, 32'h1, "ctrl_en1");
        c = cyc;
        wr(5, 32'h3, 4'hF);
        cnt_ref = '0; ref_cyc = c + 1;
        rd(2, lo_at(cyc), "clr_run");

        c = cyc;
        force dut.cnt_q = 64'h0000_0000_FFFF_FFF0;
        #1 release dut.cnt_q;
        cnt_ref = 64'h0000_0000_FFFF_FFF0; ref_cyc = c;
        repeat (4) @(negedge clock);
        rd(2, lo_at(cyc), "snap_lo");
        repeat (20) @(negedge clock);
        rd(3, 32'h0, "snap_hi");
        c = cyc;
        rd(2, lo_at(c), "snap_lo2");
        rd(3, hi_at(c), "snap_hi2");

        c = cyc;
        force dut.cnt_q = '1;
        #1 release dut.cnt_q;
        cnt_ref = '1; ref_cyc = c;
        @(negedge clock);
        rd(2, lo_at(cyc), "wrap_lo");
        rd(5, 32'h101, "ovf_set");
        wr(5, 32'h101, 4'hF);
        rd(5, 32'h1, "ovf_clr");
        c = cyc;
        force dut.cnt_q = '1;
        #1 release dut.cnt_q;
        cnt_ref = '1; ref_cyc = c;
        wr(5, 32'h101, 4'hF);
        rd(5, 32'h101, "ovf_race");

        c = cyc;
        force dut.cnt_q = 64'h0000_0005_0000_0000;
        #1 release dut.cnt_q;
        cnt_ref = 64'h0000_0005_0000_0000; ref_cyc = c;
        rd(2, lo_at(c), "pre_rst_lo");
        rd(3, 32'h5, "pre_rst_hi");

        // Reads every cycle; reset lands mid-stream and outstanding reads are discarded.
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                reset_n = 1'b0;
                sb.delete();
            end
            if (reset_n) push_exp(32'hDEAD_BE55, "stream");
            read = 1'b1; address = 4;
            @(negedge clock);
        end
        read = 1'b0;
        chk("midrst_valid", {31'b0, readdatavalid}, 32'd0);
        chk("midrst_data", readdata, 32'd0);
        reset_n = 1'b1;
        cnt_ref = '0; ref_cyc = cyc;
        rd(4, 32'h0, "rst_scratch");
        rd(5, 32'h1, "rst_ctrl");
        rd(3, 32'h0, "rst_hi");
        rd(2, lo_at(cyc), "rst_lo");

        repeat (RL + 2) @(negedge clock);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
